// File: rtl/fu_issue_buffer_pkg.sv
// rtl/fu_issue_buffer_pkg.sv - shared types for the RS->FU issue buffer
//
// Purpose: field-width macros, the control_t bundle and the fu_issue_entry_t
//          payload carried from reservation station to functional unit.
// Ports:   none (package).
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

package fu_issue_buffer_pkg;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       use_imm;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       is_branch;
  } control_t;

  typedef struct packed {
    logic [`REG_VAL_WIDTH-1:0]          src1_reg_val;
    logic [`REG_VAL_WIDTH-1:0]          src2_reg_val;
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg_addr;
    control_t                           control;
    logic [`REG_VAL_WIDTH-1:0]          immediate;
    logic [`INST_ADDR_WIDTH-1:0]        pc;
    logic [`ROB_SIZE_WIDTH-1:0]         new_inst_tag;
  } fu_issue_entry_t;

endpackage

// File: rtl/fu_issue_buffer_fifo.sv
// rtl/fu_issue_buffer_fifo.sv - single-channel issue FIFO (module fu_issue_fifo)
//
// Purpose: one RS->FU channel; DEPTH-entry circular buffer with a
//          separate occupancy counter, no input-to-output bypass.
// Ports:   clk, rst_n (async, active-low), flush
//          in_valid / in_ready / in_entry     - RS side
//          out_valid / out_ready / out_entry  - FU side
//          occupancy                          - current entry count
module fu_issue_fifo
  import fu_issue_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  fu_issue_entry_t  in_entry,
  output logic             out_valid,
  input  logic             out_ready,
  output fu_issue_entry_t  out_entry,
  output logic [OCC_W-1:0] occupancy
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  fu_issue_entry_t  mem_q [DEPTH];
  logic             push, pop;

  // Ready depends only on stored state, so a full channel refuses a push
  // even if the FU pops in the same cycle.
  assign in_ready  = (count_q != OCC_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_entry = mem_q[rd_ptr_q];
  assign occupancy = count_q;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately left out of reset; a flush drops the
  // write so a squashed entry never lands in the array.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_entry;
  end

endmodule

// File: rtl/fu_issue_buffer.sv
// rtl/fu_issue_buffer.sv - NUM_OF_FU independent RS->FU issue channels
//
// Purpose: drop-in buffer between reservation station (in_*) and
//          functional units (out_*); one fu_issue_fifo per channel, shared
//          only through flush.
// Ports:   clk, rst_n (async, active-low), flush
//          in_valid[i] / in_ready[i] / in_entry[i]     - RS side
//          out_valid[i] / out_ready[i] / out_entry[i]  - FU side
//          occupancy[i]                                - entry count
module fu_issue_buffer
  import fu_issue_buffer_pkg::*;
#(
  parameter  int NUM_OF_FU = 4,
  parameter  int DEPTH     = 4,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NUM_OF_FU-1:0] in_valid,
  output logic [NUM_OF_FU-1:0] in_ready,
  input  fu_issue_entry_t      in_entry  [NUM_OF_FU],
  output logic [NUM_OF_FU-1:0] out_valid,
  input  logic [NUM_OF_FU-1:0] out_ready,
  output fu_issue_entry_t      out_entry [NUM_OF_FU],
  output logic [OCC_W-1:0]     occupancy [NUM_OF_FU]
);

  for (genvar i = 0; i < NUM_OF_FU; i++) begin : g_ch
    fu_issue_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .in_entry  (in_entry[i]),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out_entry (out_entry[i]),
      .occupancy (occupancy[i])
    );
  end

endmodule

// File: tb/tb_fu_issue_buffer.sv
// tb/tb_fu_issue_buffer.sv - self-checking bench for fu_issue_buffer
module tb_fu_issue_buffer;
  import fu_issue_buffer_pkg::*;

  localparam int NF    = 2;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int TAG_W = `ROB_SIZE_WIDTH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [NF-1:0]   in_valid, in_ready, out_valid, out_ready;
  fu_issue_entry_t in_entry  [NF];
  fu_issue_entry_t out_entry [NF];
  logic [OCC_W-1:0] occupancy [NF];

  int total = 0;
  int bad   = 0;

  // Reference: one plain queue per channel.
  fu_issue_entry_t mq [NF][$];

  always #5 clk = ~clk;

  fu_issue_buffer #(.NUM_OF_FU(NF), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_entry  (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_entry (out_entry),
    .occupancy (occupancy)
  );

  function automatic fu_issue_entry_t make_entry(int tag);
    fu_issue_entry_t e;
    logic [31:0] r;
    e.src1_reg_val = `REG_VAL_WIDTH'($urandom);
    e.src2_reg_val = `REG_VAL_WIDTH'($urandom);
    r = $urandom;
    e.dst_reg_addr = r[`PHYSICAL_REG_NUM_WIDTH-1:0];
    r = $urandom;
    e.control = r[$bits(control_t)-1:0];
    e.immediate = `REG_VAL_WIDTH'($urandom);
    e.pc = `INST_ADDR_WIDTH'($urandom);
    e.new_inst_tag = tag[TAG_W-1:0];
    return e;
  endfunction

  // Advance one clock; model decides push/pop from its own queue sizes.
  task automatic tick();
    bit push_ok [NF];
    bit pop_ok  [NF];
    fu_issue_entry_t pe [NF];
    for (int c = 0; c < NF; c++) begin
      push_ok[c] = in_valid[c] && (mq[c].size() < DEPTH);
      pop_ok[c]  = out_ready[c] && (mq[c].size() > 0);
      pe[c]      = in_entry[c];
    end
    @(posedge clk);
    for (int c = 0; c < NF; c++) begin
      if (flush || !rst_n) mq[c].delete();
      else begin
        if (pop_ok[c]) void'(mq[c].pop_front());
        if (push_ok[c]) mq[c].push_back(pe[c]);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = '0; out_ready = '0; flush = 1'b0;
  endtask

  task automatic clear_all();
    idle(); flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_reset();
    fu_issue_entry_t e;
    #2;
    total++; if (in_ready !== 2'b11) begin bad++; $display("FAIL reset_in_ready: got %b want 11", in_ready); end
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL reset_out_valid: got %b want 00", out_valid); end
    total++; if (occupancy[0] !== 0 || occupancy[1] !== 0) begin bad++; $display("FAIL reset_occ: got %0d/%0d want 0/0", occupancy[0], occupancy[1]); end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 2'b01; e = make_entry(7); in_entry[0] = e;
    tick();
    idle();
    total++; if (occupancy[0] !== 1) begin bad++; $display("FAIL first_push_occ: got %0d want 1", occupancy[0]); end
    total++; if (out_entry[0] !== e) begin bad++; $display("FAIL first_push_data: got %h want %h", out_entry[0], e); end
    total++; if (out_valid !== 2'b01) begin bad++; $display("FAIL first_push_valid: got %b want 01", out_valid); end
  endtask

  task automatic test_fill_drain();
    clear_all();
    for (int t = 1; t <= 4; t++) begin
      in_valid = 2'b01; in_entry[0] = make_entry(t); tick();
    end
    total++; if (occupancy[0] !== 4) begin bad++; $display("FAIL fill_occ: got %0d want 4", occupancy[0]); end
    total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %b want 0", in_ready[0]); end
    in_entry[0] = make_entry(5); tick();
    total++; if (occupancy[0] !== 4) begin bad++; $display("FAIL fifth_push_occ: got %0d want 4", occupancy[0]); end
    in_valid = '0; out_ready = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      total++; if (out_valid[0] !== 1'b1 || out_entry[0].new_inst_tag !== TAG_W'(k)) begin
        bad++; $display("FAIL drain_tag: got v=%b tag=%0d want v=1 tag=%0d", out_valid[0], out_entry[0].new_inst_tag, k);
      end
      total++; if (out_entry[0] !== mq[0][0]) begin bad++; $display("FAIL drain_payload: got %h want %h", out_entry[0], mq[0][0]); end
      tick();
    end
    idle();
    total++; if (occupancy[0] !== 0 || out_valid[0] !== 1'b0) begin bad++; $display("FAIL drain_empty: got occ=%0d v=%b want 0/0", occupancy[0], out_valid[0]); end
  endtask

  task automatic test_full_push_pop();
    clear_all();
    for (int t = 11; t <= 14; t++) begin
      in_valid = 2'b01; in_entry[0] = make_entry(t); tick();
    end
    in_valid = 2'b01; out_ready = 2'b01; in_entry[0] = make_entry(15);
    tick();
    idle();
    total++; if (occupancy[0] !== 3) begin bad++; $display("FAIL full_pushpop_occ: got %0d want 3", occupancy[0]); end
    total++; if (out_entry[0].new_inst_tag !== TAG_W'(12)) begin bad++; $display("FAIL full_pushpop_head: got %0d want 12", out_entry[0].new_inst_tag); end
  endtask

  task automatic test_stream_wrap();
    int got[$];
    clear_all();
    in_valid = 2'b10; out_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      in_entry[1] = make_entry(20 + i);
      if (out_valid[1]) got.push_back(int'(out_entry[1].new_inst_tag));
      tick();
    end
    total++; if (occupancy[1] !== 1) begin bad++; $display("FAIL stream_occ: got %0d want 1", occupancy[1]); end
    in_valid = '0;
    if (out_valid[1]) got.push_back(int'(out_entry[1].new_inst_tag));
    tick();
    idle();
    total++; if (got.size() != 10) begin bad++; $display("FAIL stream_count: got %0d want 10", got.size()); end
    for (int j = 0; j < got.size(); j++) begin
      total++; if (got[j] != 20 + j) begin bad++; $display("FAIL stream_order: idx %0d got %0d want %0d", j, got[j], 20 + j); end
    end
  endtask

  task automatic test_flush();
    clear_all();
    in_valid = 2'b11; in_entry[0] = make_entry(1); in_entry[1] = make_entry(2); tick();
    in_entry[0] = make_entry(3); in_entry[1] = make_entry(4); tick();
    in_valid = 2'b01; in_entry[0] = make_entry(5); tick();
    in_valid = '0;
    total++; if (occupancy[0] !== 3 || occupancy[1] !== 2) begin bad++; $display("FAIL preflush_occ: got %0d/%0d want 3/2", occupancy[0], occupancy[1]); end
    flush = 1'b1; in_valid = 2'b01; in_entry[0] = make_entry(30);
    tick();
    idle();
    total++; if (occupancy[0] !== 0 || occupancy[1] !== 0) begin bad++; $display("FAIL flush_occ: got %0d/%0d want 0/0", occupancy[0], occupancy[1]); end
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL flush_out_valid: got %b want 00", out_valid); end
    total++; if (in_ready !== 2'b11) begin bad++; $display("FAIL flush_in_ready: got %b want 11", in_ready); end
    tick();
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL flush_dropped: got %b want 00", out_valid); end
  endtask

  task automatic test_async_reset();
    clear_all();
    in_valid = 2'b01; in_entry[0] = make_entry(1); tick();
    in_entry[0] = make_entry(2); tick();
    in_valid = '0;
    total++; if (occupancy[0] !== 2 || out_valid[0] !== 1'b1) begin bad++; $display("FAIL prereset_state: got occ=%0d v=%b want 2/1", occupancy[0], out_valid[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 2'b00) begin bad++; $display("FAIL async_reset_valid: got %b want 00", out_valid); end
    total++; if (occupancy[0] !== 0 || in_ready !== 2'b11) begin bad++; $display("FAIL async_reset_state: got occ=%0d rdy=%b want 0/11", occupancy[0], in_ready); end
    for (int c = 0; c < NF; c++) mq[c].delete();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 2'b01; in_entry[0] = make_entry(9); tick();
    in_entry[0] = make_entry(10); tick();
    in_valid = '0; out_ready = 2'b01;
    total++; if (out_entry[0].new_inst_tag !== TAG_W'(9)) begin bad++; $display("FAIL post_reset_first: got %0d want 9", out_entry[0].new_inst_tag); end
    tick();
    total++; if (out_entry[0].new_inst_tag !== TAG_W'(10)) begin bad++; $display("FAIL post_reset_second: got %0d want 10", out_entry[0].new_inst_tag); end
    tick();
    idle();
  endtask

  task automatic test_independence();
    fu_issue_entry_t head;
    int pops = 0;
    clear_all();
    for (int t = 1; t <= 4; t++) begin
      in_valid = 2'b01; in_entry[0] = make_entry(t); tick();
    end
    head = mq[0][0];
    in_valid = 2'b11; out_ready = 2'b10; in_entry[0] = make_entry(31);
    for (int i = 0; i < 8; i++) begin
      in_entry[1] = make_entry(40 + i);
      total++; if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL indep_ready1: cycle %0d got %b want 1", i, in_ready[1]); end
      total++; if (occupancy[0] !== 4 || out_entry[0] !== head) begin bad++; $display("FAIL indep_hold0: cycle %0d got occ=%0d data=%h want 4/%h", i, occupancy[0], out_entry[0], head); end
      if (out_valid[1]) pops++;
      tick();
    end
    idle();
    total++; if (pops != 7) begin bad++; $display("FAIL indep_throughput: got %0d want 7", pops); end
  endtask

  task automatic test_random();
    clear_all();
    for (int n = 0; n < 400; n++) begin
      in_valid  = NF'($urandom_range(0, 3));
      out_ready = NF'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 19) == 0);
      for (int c = 0; c < NF; c++) in_entry[c] = make_entry(int'($urandom_range(0, 31)));
      for (int c = 0; c < NF; c++) begin
        total++; if (occupancy[c] !== OCC_W'(mq[c].size())) begin bad++; $display("FAIL rand_occ: ch%0d cyc %0d got %0d want %0d", c, n, occupancy[c], mq[c].size()); end
        total++; if (out_valid[c] !== (mq[c].size() != 0)) begin bad++; $display("FAIL rand_out_valid: ch%0d cyc %0d got %b want %b", c, n, out_valid[c], mq[c].size() != 0); end
        total++; if (in_ready[c] !== (mq[c].size() != DEPTH)) begin bad++; $display("FAIL rand_in_ready: ch%0d cyc %0d got %b want %b", c, n, in_ready[c], mq[c].size() != DEPTH); end
        if (mq[c].size() > 0) begin
          total++; if (out_entry[c] !== mq[c][0]) begin bad++; $display("FAIL rand_data: ch%0d cyc %0d got %h want %h", c, n, out_entry[c], mq[c][0]); end
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int c = 0; c < NF; c++) in_entry[c] = '0;
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_stream_wrap();
    test_flush();
    test_async_reset();
    test_independence();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
